// File: rtl/mdio_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : mdio_pkg                                                     |
// | Description : Shared definitions for the MDIO management slave: framing    |
// |               state encoding, opcode values, start/turnaround bit values,  |
// |               frame field widths and data-phase terminal counts.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mdio_pkg;

    // Framing states. Bit positions inside a field are tracked by a shared
    // 5-bit bit counter rather than by per-bit states.
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        START      = 4'd1,
        OPCODE     = 4'd2,
        PHYAD      = 4'd3,
        REGAD      = 4'd4,
        TA         = 4'd5,
        READ_DATA  = 4'd6,
        WRITE_DATA = 4'd7,
        SKIP       = 4'd8
    } mdio_state_e;

    // Field widths
    localparam int c_opcode_w   = 2;
    localparam int c_phyad_w    = 5;
    localparam int c_regad_w    = 5;
    localparam int c_data_w     = 16;
    localparam int c_max_regs   = 32;
    localparam int c_pre_cnt_w  = 6;   // holds 0..32 consecutive preamble ones

    // Opcodes
    localparam logic [c_opcode_w-1:0] c_op_read  = 2'b10;
    localparam logic [c_opcode_w-1:0] c_op_write = 2'b01;

    // Start-of-frame and turnaround bit values
    localparam logic c_st0    = 1'b0;  // ends the preamble
    localparam logic c_st1    = 1'b1;
    localparam logic c_ta_wr0 = 1'b1;  // first TA bit driven by the master on a write
    localparam logic c_ta_wr1 = 1'b0;  // second TA bit driven by the master on a write
    localparam logic c_ta_rd  = 1'b0;  // value the slave drives during read turnaround

    // Terminal bit-counter values (counter starts at 0 on entry to the state)
    localparam logic [4:0] c_field5_last = 5'd4;   // last bit of PHYAD / REGAD
    localparam logic [4:0] c_opcode_last = 5'd1;
    localparam logic [4:0] c_read_last   = 5'd16;  // E18: release after 16 data bits
    localparam logic [4:0] c_wdata_last  = 5'd15;  // E18: 16th write data bit
    localparam logic [4:0] c_skip_last   = 5'd17;  // E18 of an ignored frame

endpackage
`default_nettype wire

// File: rtl/mdio_reg_bank.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : mdio_reg_bank                                                |
// | Description : Register storage for the MDIO slave. Holds NUM_REGS 16-bit   |
// |               words, commits writes to writable registers, and returns    |
// |               either the stored word or the external read-only value.     |
// | Ports       : mdc/reset_n  - clock, async active-low reset                 |
// |               we/waddr/wdata - write commit (ignored for read-only regs)   |
// |               raddr/rdata  - combinational read port                       |
// |               ro_values    - read value of read-only registers             |
// |               regs         - flattened stored register contents            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdio_reg_bank
    import mdio_pkg::*;
#(
    parameter int                                  NUM_REGS         = 32,
    parameter logic [c_max_regs*c_data_w-1:0]      REG_RESET_VALUES = '0,
    parameter logic [c_max_regs-1:0]               READ_ONLY_MASK   = '0
) (
    input  logic                         mdc,
    input  logic                         reset_n,
    input  logic                         we,
    input  logic [c_regad_w-1:0]         waddr,
    input  logic [c_data_w-1:0]          wdata,
    input  logic [c_regad_w-1:0]         raddr,
    output logic [c_data_w-1:0]          rdata,
    input  logic [NUM_REGS*c_data_w-1:0] ro_values,
    output logic [NUM_REGS*c_data_w-1:0] regs
);

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            logic [c_data_w-1:0] r_word;

            always_ff @(posedge mdc or negedge reset_n) begin
                if (!reset_n) begin
                    r_word <= REG_RESET_VALUES[i*c_data_w +: c_data_w];
                end else if (we && (waddr == 5'(i)) && !READ_ONLY_MASK[i]) begin
                    r_word <= wdata;
                end
            end

            assign regs[i*c_data_w +: c_data_w] = r_word;
        end
    endgenerate

    // Read-only registers return the live external value; the stored copy
    // of such a register never changes after reset.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 5'(i)) begin
                rdata = READ_ONLY_MASK[i] ? ro_values[i*c_data_w +: c_data_w]
                                          : regs[i*c_data_w +: c_data_w];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : mdio_slave                                                   |
// | Description : Clause-22 style MDIO management slave. Detects preamble and  |
// |               start, decodes opcode/PHY/register address, serves reads    |
// |               and writes against an internal register bank.               |
// | Ports       : mdc, reset_n          - clock (rising edge), async reset      |
// |               mdio_i/mdio_o/mdio_t  - tristate pad signals (t=1 released)   |
// |               ro_values / regs      - read-only inputs / register contents  |
// |               wr_strobe, wr_reg_addr, wr_data - one-cycle write notice      |
// |               rd_strobe, frame_error - one-cycle read / abort pulses        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [c_phyad_w-1:0]                PHY_ADDRESS      = 5'h0c,
    parameter int                                  NUM_REGS         = 32,
    parameter int                                  PREAMBLE_BITS    = 32,
    parameter logic [c_max_regs*c_data_w-1:0]      REG_RESET_VALUES = '0,
    parameter logic [c_max_regs-1:0]               READ_ONLY_MASK   = 32'h0
) (
    input  logic                         mdc,
    input  logic                         reset_n,
    input  logic                         mdio_i,
    output logic                         mdio_o,
    output logic                         mdio_t,
    input  logic [NUM_REGS*c_data_w-1:0] ro_values,
    output logic [NUM_REGS*c_data_w-1:0] regs,
    output logic                         wr_strobe,
    output logic [c_regad_w-1:0]         wr_reg_addr,
    output logic [c_data_w-1:0]          wr_data,
    output logic                         rd_strobe,
    output logic                         frame_error
);

    localparam logic [c_pre_cnt_w-1:0] c_pre_max  = 6'd32;
    localparam logic [c_pre_cnt_w-1:0] c_pre_need = 6'(PREAMBLE_BITS);
    localparam logic [c_regad_w:0]     c_num_regs = 6'(NUM_REGS);

    mdio_state_e                 r_state,      w_state_nxt;
    logic [4:0]                  r_bit_cnt,    w_bit_cnt_nxt;
    logic [c_pre_cnt_w-1:0]      r_pre_cnt,    w_pre_cnt_nxt;
    logic [c_opcode_w-1:0]       r_opcode,     w_opcode_nxt;
    logic [c_phyad_w-1:0]        r_phyad,      w_phyad_nxt;
    logic [c_regad_w-1:0]        r_regad,      w_regad_nxt;
    logic [c_data_w-1:0]         r_shift,      w_shift_nxt;
    logic                        r_mdio_o,     w_mdio_o_nxt;
    logic                        r_mdio_t,     w_mdio_t_nxt;
    logic                        r_rd_strobe,  w_rd_strobe_nxt;
    logic                        r_wr_strobe,  w_wr_strobe_nxt;
    logic                        r_frame_err,  w_frame_err_nxt;
    logic [c_regad_w-1:0]        r_wr_addr,    w_wr_addr_nxt;
    logic [c_data_w-1:0]         r_wr_data,    w_wr_data_nxt;

    logic [c_regad_w-1:0]        w_regad_full;  // register address including the bit sampled now
    logic                        w_addressed;
    logic [c_data_w-1:0]         w_wdata;       // write word including the bit sampled now
    logic [c_data_w-1:0]         w_rdata;
    logic                        w_commit;

    assign w_regad_full = {r_regad[c_regad_w-2:0], mdio_i};
    assign w_addressed  = (r_phyad == PHY_ADDRESS) && ({1'b0, w_regad_full} < c_num_regs);
    assign w_wdata      = {r_shift[c_data_w-2:0], mdio_i};

    mdio_reg_bank #(
        .NUM_REGS         (NUM_REGS),
        .REG_RESET_VALUES (REG_RESET_VALUES),
        .READ_ONLY_MASK   (READ_ONLY_MASK)
    ) u_reg_bank (
        .mdc       (mdc),
        .reset_n   (reset_n),
        .we        (w_commit),
        .waddr     (r_regad),
        .wdata     (w_wdata),
        .raddr     (r_regad),
        .rdata     (w_rdata),
        .ro_values (ro_values),
        .regs      (regs)
    );

    always_ff @(posedge mdc or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_pre_cnt   <= '0;
            r_opcode    <= '0;
            r_phyad     <= '0;
            r_regad     <= '0;
            r_shift     <= '0;
            r_mdio_o    <= 1'b0;
            r_mdio_t    <= 1'b1;
            r_rd_strobe <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_opcode    <= w_opcode_nxt;
            r_phyad     <= w_phyad_nxt;
            r_regad     <= w_regad_nxt;
            r_shift     <= w_shift_nxt;
            r_mdio_o    <= w_mdio_o_nxt;
            r_mdio_t    <= w_mdio_t_nxt;
            r_rd_strobe <= w_rd_strobe_nxt;
            r_wr_strobe <= w_wr_strobe_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_pre_cnt_nxt   = r_pre_cnt;
        w_opcode_nxt    = r_opcode;
        w_phyad_nxt     = r_phyad;
        w_regad_nxt     = r_regad;
        w_shift_nxt     = r_shift;
        w_mdio_o_nxt    = r_mdio_o;
        w_mdio_t_nxt    = r_mdio_t;
        w_rd_strobe_nxt = 1'b0;
        w_wr_strobe_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_commit        = 1'b0;

        case (r_state)
            IDLE: begin
                if (mdio_i != c_st0) begin
                    if (r_pre_cnt != c_pre_max) begin
                        w_pre_cnt_nxt = r_pre_cnt + 6'd1;
                    end
                end else if (r_pre_cnt >= c_pre_need) begin
                    // This 0 is the first start bit.
                    w_state_nxt   = START;
                    w_pre_cnt_nxt = '0;
                end else begin
                    w_pre_cnt_nxt = '0;
                end
            end

            START: begin
                w_bit_cnt_nxt = '0;
                if (mdio_i == c_st1) begin
                    w_state_nxt = OPCODE;
                end else begin
                    w_state_nxt     = IDLE;
                    w_pre_cnt_nxt   = '0;
                    w_frame_err_nxt = 1'b1;
                end
            end

            OPCODE: begin
                w_opcode_nxt = {r_opcode[0], mdio_i};
                if (r_bit_cnt == c_opcode_last) begin
                    w_state_nxt   = PHYAD;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            PHYAD: begin
                w_phyad_nxt = {r_phyad[c_phyad_w-2:0], mdio_i};
                if (r_bit_cnt == c_field5_last) begin
                    w_state_nxt   = REGAD;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            REGAD: begin
                w_regad_nxt = w_regad_full;
                if (r_bit_cnt == c_field5_last) begin
                    // E0: the whole header is known, decide whether to serve it.
                    w_bit_cnt_nxt = '0;
                    if (w_addressed && ((r_opcode == c_op_read) || (r_opcode == c_op_write))) begin
                        w_state_nxt = TA;
                    end else begin
                        w_state_nxt = SKIP;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            TA: begin
                if (r_opcode == c_op_read) begin
                    // E1: take the bus, drive the TA zero and freeze the read word.
                    w_mdio_t_nxt    = 1'b0;
                    w_mdio_o_nxt    = c_ta_rd;
                    w_shift_nxt     = w_rdata;
                    w_rd_strobe_nxt = 1'b1;
                    w_state_nxt     = READ_DATA;
                    w_bit_cnt_nxt   = '0;
                end else if ((r_bit_cnt == '0) && (mdio_i == c_ta_wr0)) begin
                    w_bit_cnt_nxt = 5'd1;
                end else if ((r_bit_cnt != '0) && (mdio_i == c_ta_wr1)) begin
                    w_state_nxt   = WRITE_DATA;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_state_nxt     = IDLE;
                    w_bit_cnt_nxt   = '0;
                    w_pre_cnt_nxt   = '0;
                    w_frame_err_nxt = 1'b1;
                end
            end

            READ_DATA: begin
                if (r_bit_cnt == c_read_last) begin
                    w_mdio_t_nxt  = 1'b1;
                    w_mdio_o_nxt  = 1'b0;
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                    w_pre_cnt_nxt = '0;
                end else begin
                    w_mdio_o_nxt  = r_shift[c_data_w-1];
                    w_shift_nxt   = {r_shift[c_data_w-2:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            WRITE_DATA: begin
                w_shift_nxt = w_wdata;
                if (r_bit_cnt == c_wdata_last) begin
                    // The bank ignores the commit for read-only registers, but the
                    // notification is still raised.
                    w_commit        = 1'b1;
                    w_wr_strobe_nxt = 1'b1;
                    w_wr_addr_nxt   = r_regad;
                    w_wr_data_nxt   = w_wdata;
                    w_state_nxt     = IDLE;
                    w_bit_cnt_nxt   = '0;
                    w_pre_cnt_nxt   = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            SKIP: begin
                if (r_bit_cnt == c_skip_last) begin
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                    w_pre_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = '0;
                w_pre_cnt_nxt = '0;
                w_mdio_t_nxt  = 1'b1;
                w_mdio_o_nxt  = 1'b0;
            end
        endcase
    end

    assign mdio_o      = r_mdio_o;
    assign mdio_t      = r_mdio_t;
    assign rd_strobe   = r_rd_strobe;
    assign wr_strobe   = r_wr_strobe;
    assign frame_error = r_frame_err;
    assign wr_reg_addr = r_wr_addr;
    assign wr_data     = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_mdio_slave                                                |
// | Description : Directed self-checking bench for mdio_slave. Plays MDIO      |
// |               master frames bit by bit and compares against hand-computed |
// |               expected values.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mdio_slave;

    localparam int             NREGS    = 32;
    localparam logic [511:0]   RST_VALS = {464'h0, 16'h1234, 32'h0};  // reg 2 = 0x1234
    localparam logic [31:0]    RO_MASK  = 32'h0000_0002;              // reg 1 read-only
    localparam logic [4:0]     MY_PHY   = 5'h0c;

    logic                 mdc = 1'b0;
    logic                 reset_n;
    logic                 mdio_i;
    logic                 mdio_o;
    logic                 mdio_t;
    logic [NREGS*16-1:0]  ro_values;
    logic [NREGS*16-1:0]  regs;
    logic                 wr_strobe;
    logic [4:0]           wr_reg_addr;
    logic [15:0]          wr_data;
    logic                 rd_strobe;
    logic                 frame_error;

    int n_checks = 0;
    int n_errors = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          fe_cnt = 0;
    logic [4:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;

    logic [15:0] data;
    logic        ta_ok, held, rel;
    int          rd0, wr0, fe0;

    mdio_slave #(
        .PHY_ADDRESS      (MY_PHY),
        .NUM_REGS         (NREGS),
        .PREAMBLE_BITS    (32),
        .REG_RESET_VALUES (RST_VALS),
        .READ_ONLY_MASK   (RO_MASK)
    ) dut (
        .mdc         (mdc),
        .reset_n     (reset_n),
        .mdio_i      (mdio_i),
        .mdio_o      (mdio_o),
        .mdio_t      (mdio_t),
        .ro_values   (ro_values),
        .regs        (regs),
        .wr_strobe   (wr_strobe),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .rd_strobe   (rd_strobe),
        .frame_error (frame_error)
    );

    always #5 mdc = ~mdc;

    // Pulse monitor, sampled half a cycle away from the active edge.
    always @(negedge mdc) begin
        if (rd_strobe)   rd_cnt++;
        if (frame_error) fe_cnt++;
        if (wr_strobe) begin
            wr_cnt++;
            last_wr_addr = wr_reg_addr;
            last_wr_data = wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one bit on the falling edge; return just after the rising edge
    // that samples it, so registered outputs of that edge are visible.
    task automatic clk_bit(input logic b);
        @(negedge mdc);
        mdio_i = b;
        @(posedge mdc);
        #1;
    endtask

    // Preamble, ST, opcode, PHY and register address; last bit is E0.
    task automatic send_header(input int npre, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] ra);
        for (int i = 0; i < npre; i++) clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b1);
        for (int i = 1; i >= 0; i--) clk_bit(op[i]);
        for (int i = 4; i >= 0; i--) clk_bit(phy[i]);
        for (int i = 4; i >= 0; i--) clk_bit(ra[i]);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              output logic [15:0] d, output logic ta, output logic hld,
                              output logic rls);
        send_header(32, 2'b10, phy, ra);
        clk_bit(1'b1);                                  // E1
        ta  = (mdio_t === 1'b0) && (mdio_o === 1'b0);
        hld = 1'b1;
        d   = '0;
        for (int k = 0; k < 16; k++) begin              // E2..E17
            clk_bit(1'b1);
            d = {d[14:0], mdio_o};
            if (mdio_t !== 1'b0) hld = 1'b0;
        end
        clk_bit(1'b1);                                  // E18
        rls = (mdio_t === 1'b1);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra,
                               input logic [1:0] ta, input logic [15:0] d);
        send_header(32, 2'b01, phy, ra);
        clk_bit(ta[1]);
        clk_bit(ta[0]);
        for (int k = 15; k >= 0; k--) clk_bit(d[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n   = 1'b0;
        mdio_i    = 1'b1;
        ro_values = '0;
        ro_values[1*16 +: 16]  = 16'h796d;
        ro_values[24*16 +: 16] = 16'hdead;   // writable reg: must be ignored

        repeat (3) @(posedge mdc);
        #1;
        check("rst_mdio_t",  mdio_t, 1);
        check("rst_mdio_o",  mdio_o, 0);
        check("rst_pulses",  {rd_strobe, wr_strobe, frame_error}, 0);
        check("rst_reg2",    regs[2*16 +: 16], 16'h1234);
        check("rst_reg24",   regs[24*16 +: 16], 16'h0000);
        @(negedge mdc);
        reset_n = 1'b1;

        // Read of reset value
        rd0 = rd_cnt;
        read_frame(MY_PHY, 5'd2, data, ta_ok, held, rel);
        clk_bit(1'b1);
        check("rd2_ta",      ta_ok, 1);
        check("rd2_data",    data, 16'h1234);
        check("rd2_driven",  held, 1);
        check("rd2_release", rel, 1);
        check("rd2_strobes", rd_cnt - rd0, 1);

        // Write then read back
        wr0 = wr_cnt;
        write_frame(MY_PHY, 5'd24, 2'b10, 16'haaa5);
        check("wr24_reg",    regs[24*16 +: 16], 16'haaa5);
        clk_bit(1'b1);
        check("wr24_strobes", wr_cnt - wr0, 1);
        check("wr24_addr",   last_wr_addr, 5'd24);
        check("wr24_data",   last_wr_data, 16'haaa5);
        read_frame(MY_PHY, 5'd24, data, ta_ok, held, rel);
        check("rd24_data",   data, 16'haaa5);

        // Writes to a read-only register
        wr0 = wr_cnt;
        write_frame(MY_PHY, 5'd1, 2'b10, 16'h0000);
        write_frame(MY_PHY, 5'd1, 2'b10, 16'hbeef);
        clk_bit(1'b1);
        check("ro_strobes",  wr_cnt - wr0, 2);
        check("ro_addr",     last_wr_addr, 5'd1);
        check("ro_wdata",    last_wr_data, 16'hbeef);
        check("ro_reg_kept", regs[1*16 +: 16], 16'h0000);
        read_frame(MY_PHY, 5'd1, data, ta_ok, held, rel);
        check("ro_rd_data",  data, 16'h796d);

        // Frame for another PHY, then an immediate frame for this one
        rd0 = rd_cnt; wr0 = wr_cnt; fe0 = fe_cnt;
        send_header(32, 2'b10, 5'h03, 5'd2);
        held = 1'b1;
        for (int k = 0; k < 18; k++) begin
            clk_bit(1'b1);
            if (mdio_t !== 1'b1) held = 1'b0;
        end
        check("phy3_released", held, 1);
        check("phy3_no_pulse", {rd_cnt - rd0, wr_cnt - wr0, fe_cnt - fe0}, 0);
        read_frame(MY_PHY, 5'd2, data, ta_ok, held, rel);
        clk_bit(1'b1);
        check("phy3_next_data", data, 16'h1234);
        check("phy3_next_rd",  rd_cnt - rd0, 1);

        // Write with a bad turnaround
        wr0 = wr_cnt; fe0 = fe_cnt;
        write_frame(MY_PHY, 5'd24, 2'b00, 16'h1111);
        clk_bit(1'b1);
        check("ta_err_fe",   fe_cnt - fe0, 1);
        check("ta_err_wr",   wr_cnt - wr0, 0);
        check("ta_err_reg",  regs[24*16 +: 16], 16'haaa5);

        // Bad start sequence
        fe0 = fe_cnt;
        for (int i = 0; i < 32; i++) clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b0);
        clk_bit(1'b1);
        check("st_err_fe",   fe_cnt - fe0, 1);

        // Too short a preamble: frame ignored
        rd0 = rd_cnt;
        send_header(20, 2'b10, MY_PHY, 5'd2);
        held = 1'b1;
        for (int k = 0; k < 18; k++) begin
            clk_bit(1'b1);
            if (mdio_t !== 1'b1) held = 1'b0;
        end
        check("short_pre_released", held, 1);
        check("short_pre_no_rd", rd_cnt - rd0, 0);

        // Asynchronous reset in the middle of a read
        send_header(32, 2'b10, MY_PHY, 5'd2);
        for (int k = 0; k < 8; k++) clk_bit(1'b1);  // E1..E8
        check("midrd_driving", mdio_t, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrd_rst_t",   mdio_t, 1);
        check("midrd_rst_o",   mdio_o, 0);
        check("midrd_rst_reg", regs[24*16 +: 16], 16'h0000);
        @(negedge mdc);
        reset_n = 1'b1;
        read_frame(MY_PHY, 5'd2, data, ta_ok, held, rel);
        check("post_rst_data", data, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PHY_ADDRESS, default 5'h0c: PHY address this slave answers to.
REQ-002 SHALL have parameter NUM_REGS, default 32, legal 1..32: implemented registers 0..NUM_REGS-1.
REQ-003 SHALL have parameter PREAMBLE_BITS, default 32, legal 0..32: consecutive 1s required before ST.
REQ-004 SHALL have parameter REG_RESET_VALUES, default all 16'h0000, 32x16 flat: per-register reset value.
REQ-005 SHALL have parameter READ_ONLY_MASK, default 32'h0: bit n=1 makes register n read-only.
REQ-006 SHALL have port mdc, input, 1: the only clock; all sampling and driving on rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports mdio_i (input, 1), mdio_o (output, 1), mdio_t (output, 1; 1 = released): discrete tristate signals.
REQ-009 SHALL have port ro_values, input, NUM_REGS*16: read value of read-only registers.
REQ-010 SHALL have port regs, output, NUM_REGS*16: current writable register contents.
REQ-011 SHALL have ports wr_strobe (output, 1), wr_reg_addr (output, 5), wr_data (output, 16): one-cycle write notification.
REQ-012 SHALL have ports rd_strobe (output, 1): one-cycle pulse per served read; frame_error (output, 1): one-cycle pulse per aborted frame.

Function
REQ-013 SHALL implement states IDLE, START, OPCODE, PHYAD, REGAD, TA, READ_DATA, WRITE_DATA, SKIP, sequenced by one 5-bit bit counter, not per-bit states.
REQ-014 IDLE: SHALL count consecutive sampled 1s, saturating at 32; a 0 with count >= PREAMBLE_BITS SHALL enter START; a 0 otherwise SHALL clear count.
REQ-015 START: sampled 1 -> OPCODE; sampled 0 -> IDLE, count 0, frame_error pulse.
REQ-016 OPCODE, PHYAD, REGAD: SHALL shift 2, 5, 5 bits MSB first.
REQ-017 Edge E0 = edge sampling REGAD[0]; frame "addressed" when PHYAD == PHY_ADDRESS and REGAD < NUM_REGS.
REQ-018 Opcode 00 or 11, or not addressed: SHALL enter SKIP, keep mdio_t=1 for 18 further edges (E1..E18), return to IDLE with count 0; no strobes.
REQ-019 Read (10), addressed: at E1 SHALL set mdio_t=0, mdio_o=0, snapshot read data (ro_values word if READ_ONLY_MASK bit set, else regs word); rd_strobe high for the cycle after E1.
REQ-020 Read: at E2..E17 SHALL drive snapshot bits 15..0; at E18 SHALL set mdio_t=1 and enter IDLE, count 0.
REQ-021 Write (01), addressed: E1 SHALL sample 1 and E2 sample 0, else frame_error pulse and IDLE; mdio_t stays 1 throughout write.
REQ-022 Write: E3..E18 SHALL shift data MSB first; at E18 SHALL commit to the register unless read-only, and pulse wr_strobe with wr_reg_addr/wr_data for one cycle even when read-only (data discarded).
REQ-023 A write landing on a read-only register SHALL leave regs unchanged.
REQ-024 Writes and reads during the same frame cannot overlap; a write commit SHALL be visible to a read in the next frame.
REQ-025 With PREAMBLE_BITS=0, the first 0 sampled in IDLE SHALL be taken as ST[1].
REQ-026 Unimplemented regs slices (index >= NUM_REGS) SHALL not exist; ro_values bits of writable registers SHALL be ignored.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, counters 0, mdio_t=1, mdio_o=0, strobes 0, frame_error 0, regs = REG_RESET_VALUES.
REQ-028 Reset mid-read SHALL release the line asynchronously; reset mid-write SHALL discard the partial frame without commit.

Structure
REQ-029 Shared package mdio_pkg SHALL hold the state enum, opcode constants (READ 2'b10, WRITE 2'b01), ST/TA bit constants and field widths.
REQ-030 Register storage, read-only muxing and write commit SHALL be a sub-module mdio_reg_bank; framing FSM stays in mdio_slave.

Verification
REQ-031 Reset then read reg 2 with REG_RESET_VALUES[2]=16'h1234 -> TA 0 at E1, bits 0x1234 MSB first E2..E17, mdio_t=1 at E18, one rd_strobe.
REQ-032 Write 16'haaa5 to reg 24, then read reg 24 -> wr_strobe once with addr 24 data 0xaaa5; read returns 0xaaa5.
REQ-033 READ_ONLY_MASK bit 1 set, ro_values[1]=16'h796d, write 16'h0000 to reg 1 -> wr_strobe pulses, read returns 0x796d.
REQ-034 Read to PHY 5'h03 -> mdio_t stays 1 for full frame, no strobes; immediate following frame to PHY_ADDRESS is served.
REQ-035 Write with TA sampled 0,0 -> frame_error pulse, no wr_strobe, register unchanged.
REQ-036 Only 20 preamble 1s with PREAMBLE_BITS=32 -> frame ignored, mdio_t stays 1; reset_n low at E8 of a read -> mdio_t=1 immediately.
